// File: rtl/sd_wb_slave_regs.sv
// ---------------------------------------------------------------------------
// sd_wb_slave_regs
//
// Wishbone slave register block of the SD host controller. It terminates every
// bus cycle from the IWishboneBus slave modport, holds the operation / start /
// end block address registers, and streams block data between the bus and
// the SD controller core.
//
// Port names follow the bus interface (master perspective): signals ending in
// _O are inputs here, signals ending in _I are outputs.
//
// Ports:
//   CLK_I, RST_I      clock (rising edge) and asynchronous active-low reset
//   CYC_O, STB_O      bus cycle / strobe
//   WE_O, ADR_O       write enable, register select (bus bits [6:4])
//   DAT_O, SEL_O      write data, byte select (access ignored+acked if 0)
//   CTI_O             cycle type: 000 classic, 010 incr burst, 111 end burst
//   ACK_I, ERR_I      acknowledge / error (one cycle each)
//   RTY_I             retry, always 0
//   DAT_I             read data, valid in the ACK_I cycle
//   oReqValid/oReqOp  operation request (01 read block, 10 write block)
//   oStartAddr/oEndAddr  block address range of the request
//   iReqAck           one-cycle pulse: request taken by the SD core
//   iRdData/iRdValid/oRdReady   read stream from the SD core (oRdReady = pop)
//   oWrData/oWrValid/iWrReady   write stream to the SD core
//
// Register map (ADR_O):
//   000 CTRL   W: Op <= DAT_O[1:0], request raised for Op 01/10
//              R: {.., Op[1:0], oReqValid}
//   001 START  R/W
//   010 END    R/W
//   011 RDDATA R only
//   100 WRDATA W only
//   anything else (and the wrong direction on the data ports): ERR_I
// ---------------------------------------------------------------------------
module sd_wb_slave_regs #(
    parameter int gWidth     = 32,
    parameter int gRdTimeout = 1024
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CYC_O,
    input  logic              STB_O,
    input  logic              WE_O,
    input  logic [2:0]        ADR_O,
    input  logic [gWidth-1:0] DAT_O,
    input  logic              SEL_O,
    input  logic [2:0]        CTI_O,
    output logic              ACK_I,
    output logic              ERR_I,
    output logic              RTY_I,
    output logic [gWidth-1:0] DAT_I,
    output logic              oReqValid,
    output logic [1:0]        oReqOp,
    output logic [31:0]       oStartAddr,
    output logic [31:0]       oEndAddr,
    input  logic              iReqAck,
    input  logic [gWidth-1:0] iRdData,
    input  logic              iRdValid,
    output logic              oRdReady,
    output logic [gWidth-1:0] oWrData,
    output logic              oWrValid,
    input  logic              iWrReady
);

    localparam logic [2:0] ADR_CTRL   = 3'b000;
    localparam logic [2:0] ADR_START  = 3'b001;
    localparam logic [2:0] ADR_END    = 3'b010;
    localparam logic [2:0] ADR_RDDATA = 3'b011;
    localparam logic [2:0] ADR_WRDATA = 3'b100;

    localparam logic [2:0] CTI_INCR   = 3'b010;

    localparam int CNT_W = (gRdTimeout > 1) ? $clog2(gRdTimeout) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(gRdTimeout - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             burst_reg;   // the beat just acked announced a follow-on beat

    // Decode of whatever the bus presents this cycle.
    logic req;
    logic is_rd_data;
    logic is_wr_data;
    logic illegal;
    logic data_ready;
    logic go_err;
    logic go_wait;
    logic go_ack;
    logic can_start;   // FSM is in a position to accept a new beat
    logic take_effect; // a beat is acked this edge and carries side effects
    logic reg_writable;

    always_comb begin
        req          = CYC_O && STB_O;
        is_rd_data   = (ADR_O == ADR_RDDATA);
        is_wr_data   = (ADR_O == ADR_WRDATA);
        illegal      = (ADR_O > ADR_WRDATA) || (WE_O && is_rd_data) || (!WE_O && is_wr_data);
        data_ready   = 1'b1;
        if (is_rd_data) begin
            data_ready = iRdValid;
        end else if (is_wr_data) begin
            data_ready = iWrReady;
        end
        // SEL_O=0 beats are acked untouched, so they never error or wait.
        go_err       = req && SEL_O && illegal;
        go_wait      = req && SEL_O && !illegal && !data_ready;
        go_ack       = req && !go_err && !go_wait;
        can_start    = (state_reg == ST_IDLE) || (state_reg == ST_WAIT) ||
                       ((state_reg == ST_ACK) && burst_reg);
        take_effect  = can_start && go_ack && SEL_O;
        // A request being acknowledged this very edge frees the registers.
        reg_writable = !oReqValid || iReqAck;
    end

    assign RTY_I = 1'b0;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            burst_reg    <= 1'b0;
            ACK_I        <= 1'b0;
            ERR_I        <= 1'b0;
            DAT_I        <= '0;
            oReqValid    <= 1'b0;
            oReqOp       <= 2'b00;
            oStartAddr   <= '0;
            oEndAddr     <= '0;
            oRdReady     <= 1'b0;
            oWrData      <= '0;
            oWrValid     <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            ACK_I    <= 1'b0;
            ERR_I    <= 1'b0;
            DAT_I    <= '0;
            oRdReady <= 1'b0;
            oWrValid <= 1'b0;

            if (iReqAck) begin
                oReqValid <= 1'b0;
            end

            unique case (state_reg)
                ST_IDLE, ST_ACK: begin
                    // From ST_ACK only a running burst may accept another beat;
                    // otherwise the access is finished and we fall back to idle.
                    if (can_start && go_err) begin
                        state_reg <= ST_ERR;
                        ERR_I     <= 1'b1;
                    end else if (can_start && go_wait) begin
                        state_reg    <= ST_WAIT;
                        wait_cnt_reg <= '0;
                    end else if (can_start && go_ack) begin
                        state_reg <= ST_ACK;
                        ACK_I     <= 1'b1;
                        burst_reg <= (CTI_O == CTI_INCR);
                    end else begin
                        state_reg <= ST_IDLE;
                        burst_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_reg <= ST_IDLE;
                        burst_reg <= 1'b0;
                    end else if (go_ack) begin
                        state_reg <= ST_ACK;
                        ACK_I     <= 1'b1;
                        burst_reg <= (CTI_O == CTI_INCR);
                    end else if (go_err || (wait_cnt_reg == CNT_LAST)) begin
                        state_reg <= ST_ERR;
                        ERR_I     <= 1'b1;
                        burst_reg <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_ERR: begin
                    // Error cycle is a full cycle; STB_O is still the old beat here.
                    state_reg <= ST_IDLE;
                    burst_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    burst_reg <= 1'b0;
                end
            endcase

            // Side effects land with the edge that raises ACK_I.
            if (take_effect) begin
                if (WE_O) begin
                    case (ADR_O)
                        ADR_CTRL: begin
                            if (reg_writable) begin
                                oReqOp <= DAT_O[1:0];
                                if ((DAT_O[1:0] == 2'b01) || (DAT_O[1:0] == 2'b10)) begin
                                    oReqValid <= 1'b1;
                                end
                            end
                        end
                        ADR_START: begin
                            if (reg_writable) begin
                                oStartAddr <= DAT_O[31:0];
                            end
                        end
                        ADR_END: begin
                            if (reg_writable) begin
                                oEndAddr <= DAT_O[31:0];
                            end
                        end
                        ADR_WRDATA: begin
                            oWrData  <= DAT_O;
                            oWrValid <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    case (ADR_O)
                        ADR_CTRL:   DAT_I <= {{(gWidth-3){1'b0}}, oReqOp, oReqValid};
                        ADR_START:  DAT_I <= gWidth'(oStartAddr);
                        ADR_END:    DAT_I <= gWidth'(oEndAddr);
                        ADR_RDDATA: begin
                            DAT_I    <= iRdData;
                            oRdReady <= 1'b1;
                        end
                        default:    DAT_I <= '0;
                    endcase
                end
            end
        end
    end

endmodule
